pwm_led_chaser: RTL and testbench
=================================

# pwm_led_chaser

Parametrised PWM LED chaser: drives `N_LEDS` outputs, each with its own duty level, and rotates the duty profile one position every `STEP_TICKS` clocks to produce a moving brightness gradient. It generalises the fixed 10-LED / 100-step chaser with these additions:
- configurable LED count, PWM resolution and step rate
- rotate and bounce modes, plus an enable
- a step strobe for downstream sequencing
- optional gamma correction

It sits directly between board clock/switches and the LED pins.

## Interface
- `N_LEDS`, 10, number of channels (≥2)
- `PWM_PERIOD`, 100, PWM frame length in clocks (≥2); duty range 0..PWM_PERIOD
- `STEP_TICKS`, 25_000_000, clocks between profile rotations (≥1)
- `clk` input 1, single system clock
- `rst` input 1, synchronous active-high reset
- `en` input 1, 1 = rotation advances; 0 = profile frozen, PWM keeps running
- `sentido` input 1, rotate-mode direction: 1 = toward index 0, 0 = toward index N_LEDS-1
- `mode` input 1, 0 = rotate, 1 = bounce
- `led` output N_LEDS, PWM outputs, registered
- `step_o` output 1, one-cycle strobe after each rotation, registered

## Operation
- Widths:
  - `PWM_W = $clog2(PWM_PERIOD+1)` for the duty registers and the PWM counter.
  - `$clog2(STEP_TICKS)` for the step counter (min 1).
  - All arithmetic is unsigned.
- Reset values:
  - `duty[i] = (i*PWM_PERIOD)/N_LEDS`, truncating.
  - `pwm_cnt = 0`, `step_cnt = 0`, `led = 0`, `step_o = 0`.
  - Internal direction `dir = 1`; bounce counter `bcnt = 0`.
- `pwm_cnt`: free-running 0..PWM_PERIOD-1, wraps to 0. Ignores `en`.
- `led[i] <= (pwm_cnt < duty[i])`:
  - duty 0 → always off.
  - duty PWM_PERIOD → always on.
- `step_cnt` counts only while `en`=1 and holds while `en`=0. The step event fires when `step_cnt == STEP_TICKS-1` and `en`=1; at that edge `step_cnt <= 0`.
- Rotate mode, on a step event:
  - Effective direction is the `sentido` value sampled at that edge; `dir <= sentido`.
  - dir=1: `duty[j] <= duty[j+1]`, `duty[N-1] <= duty[0]`.
  - dir=0: `duty[j] <= duty[j-1]`, `duty[0] <= duty[N-1]`.
  - `bcnt` held at 0.
- Bounce mode, on a step event:
  - `sentido` is ignored; the rotation uses the current `dir` with the same wrap rules.
  - If `bcnt == N_LEDS-2`: `bcnt <= 0` and `dir <= ~dir`.
  - Otherwise `bcnt <= bcnt+1`.
  - Result: direction reverses after every N_LEDS-1 steps.
- Mode switch takes effect at the next step event. Switching bounce→rotate clears `bcnt`; switching rotate→bounce starts from the last `dir`.
- Duty values are only permuted, never altered; the multiset of duties is invariant.

## Timing
- A step event at edge k gives:
  - new `duty` visible after edge k;
  - `step_o`=1 for exactly the cycle after edge k;
  - `led` reflects the new duty from edge k+1 (one-cycle compare latency).
- `led` is registered and glitch-free. Latency from `pwm_cnt`/`duty` to `led` is 1 clock.
- `rst` asserted at any edge, including mid-frame or during a step event, forces all reset values at that edge. Reset has priority over the step event.
- `en` falling on the edge where `step_cnt == STEP_TICKS-1`: no step; `step_cnt` holds at STEP_TICKS-1 and the step fires on the first edge with `en`=1.
- STEP_TICKS=1 with `en`=1: a step event on every clock.

## Configuration
- `PWM_LED_GAMMA_EN` defined:
  - Compare value is `g(duty[i]) = (duty[i]*duty[i])/PWM_PERIOD`, truncating, with a `2*PWM_W`-bit intermediate.
  - `led[i] <= (pwm_cnt < g(duty[i]))`.
  - g(0)=0 and g(PWM_PERIOD)=PWM_PERIOD.
- Not defined: compare uses `duty[i]` directly.
- Stored duty values and rotation are identical in both builds.

## Test plan
Tests 1–4 use N_LEDS=4, PWM_PERIOD=8, STEP_TICKS=5. Tests 5–6 use the defaults.
1. Reset, `en`=0, observe 16 clocks:
   - duties 0,2,4,6;
   - `led[0]` never high; `led[1]` high 2 of 8; `led[3]` high 6 of 8;
   - `step_o` never high.
2. Rotate, `sentido`=1, `en`=1:
   - first `step_o` on the 6th cycle after reset release;
   - duties become 2,4,6,0;
   - a second step gives 4,6,0,2.
3. Bounce, `en`=1, 6 steps: duty[0] sequence 2,4,6, then 4,2,0. The reversal after 3 steps confirms `dir` flipped.
4. `en` dropped for 20 clocks mid-interval, then raised:
   - `step_cnt` holds and duties are frozen;
   - the next step arrives exactly (5 − elapsed) enabled clocks later.
5. `rst` pulsed 1 cycle on a step edge: duties return to 0,10,20,…,90 and `step_o`=0 on the next cycle.
6. With `PWM_LED_GAMMA_EN`, duty 30: `led` high 9 of 100 clocks. Without the macro: high 30 of 100.

Source files
------------

// File: rtl/pwm_led_chaser.sv
`default_nettype none
// ============================================================================
// Module      : pwm_led_chaser
// Description : Parametrised PWM LED chaser. Each of N_LEDS channels has a
//               stored duty level. A shared free-running PWM counter is
//               compared against every duty level. Every STEP_TICKS enabled
//               clocks the duty profile is rotated one position, which makes
//               a brightness gradient move along the LEDs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_LEDS      number of LED channels (>= 2)
//   PWM_PERIOD  PWM frame length in clocks (>= 2); duty range 0..PWM_PERIOD
//   STEP_TICKS  enabled clocks between profile rotations (>= 1)
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   1 = rotation advances, 0 = profile frozen (PWM keeps running)
//   sentido  in   rotate-mode direction: 1 = toward index 0,
//                 0 = toward index N_LEDS-1
//   mode     in   0 = rotate, 1 = bounce
//   led      out  registered PWM outputs, one per channel
//   step_o   out  registered one-cycle strobe after each rotation
// Build option
//   PWM_LED_GAMMA_EN  when defined, each channel compares against the
//                     gamma-corrected level (duty*duty)/PWM_PERIOD instead of
//                     the raw duty. Stored duties and rotation are unchanged.
// ============================================================================
module pwm_led_chaser #(
  parameter int N_LEDS     = 10,
  parameter int PWM_PERIOD = 100,
  parameter int STEP_TICKS = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sentido,
  input  logic              mode,
  output logic [N_LEDS-1:0] led,
  output logic              step_o
);

  localparam int PWM_W  = $clog2(PWM_PERIOD + 1);
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  // The bounce counter only ever reaches N_LEDS-2.
  localparam int BCNT_W = (N_LEDS > 2) ? $clog2(N_LEDS - 1) : 1;

  localparam logic [PWM_W-1:0]  c_pwm_last  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEP_TICKS - 1);
  localparam logic [BCNT_W-1:0] c_bcnt_last = BCNT_W'(N_LEDS - 2);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PWM_W-1:0]  r_duty [N_LEDS];
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [STEP_W-1:0] r_step_cnt;
  logic              r_dir;
  logic [BCNT_W-1:0] r_bcnt;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic              w_step;
  logic              w_rot_dir;
  logic              w_dir_nxt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic [PWM_W-1:0]  w_duty_rot [N_LEDS];
  logic [N_LEDS-1:0] w_on;

  assign w_step = en && (r_step_cnt == c_step_last);

  // Rotate mode follows the live sentido input; bounce mode keeps its own
  // direction and ignores sentido.
  assign w_rot_dir = mode ? r_dir : sentido;

  always_comb begin
    w_dir_nxt  = r_dir;
    w_bcnt_nxt = r_bcnt;
    if (w_step) begin
      if (mode) begin
        // Reverse after N_LEDS-1 steps. The rotation on this edge still uses
        // the old direction; the flip applies from the next step onward.
        if (r_bcnt == c_bcnt_last) begin
          w_bcnt_nxt = '0;
          w_dir_nxt  = ~r_dir;
        end else begin
          w_bcnt_nxt = r_bcnt + BCNT_W'(1);
        end
      end else begin
        // Remember the rotate direction so a later switch to bounce starts
        // from it.
        w_dir_nxt  = sentido;
        w_bcnt_nxt = '0;
      end
    end
  end

  // Rotated profile: dir=1 pulls from the higher index (pattern moves toward
  // index 0), dir=0 pulls from the lower index; both wrap around.
  for (genvar j = 0; j < N_LEDS; j++) begin : g_rot
    localparam int c_up = (j + 1) % N_LEDS;
    localparam int c_dn = (j + N_LEDS - 1) % N_LEDS;
    assign w_duty_rot[j] = w_rot_dir ? r_duty[c_up] : r_duty[c_dn];
  end

  // Per-channel compare against the PWM counter.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_cmp
`ifdef PWM_LED_GAMMA_EN
    localparam logic [2*PWM_W-1:0] c_period_w2 = (2*PWM_W)'(PWM_PERIOD);
    logic [2*PWM_W-1:0] w_duty_w2;
    logic [2*PWM_W-1:0] w_sq;
    logic [2*PWM_W-1:0] w_gamma;
    assign w_duty_w2 = {{PWM_W{1'b0}}, r_duty[i]};
    assign w_sq      = w_duty_w2 * w_duty_w2;
    // Quotient never exceeds PWM_PERIOD, so comparing in the wide domain
    // is exact and avoids a truncating slice.
    assign w_gamma   = w_sq / c_period_w2;
    assign w_on[i]   = ({{PWM_W{1'b0}}, r_pwm_cnt} < w_gamma);
`else
    assign w_on[i]   = (r_pwm_cnt < r_duty[i]);
`endif
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LEDS; i++) begin
        r_duty[i] <= PWM_W'((i * PWM_PERIOD) / N_LEDS);
      end
      r_pwm_cnt  <= '0;
      r_step_cnt <= '0;
      r_dir      <= 1'b1;
      r_bcnt     <= '0;
      led        <= '0;
      step_o     <= 1'b0;
    end else begin
      led    <= w_on;
      step_o <= w_step;

      r_pwm_cnt <= (r_pwm_cnt == c_pwm_last) ? '0 : r_pwm_cnt + PWM_W'(1);

      // Counter holds while disabled, so a step that was due when en fell
      // fires on the first enabled edge.
      if (w_step) begin
        r_step_cnt <= '0;
      end else if (en) begin
        r_step_cnt <= r_step_cnt + STEP_W'(1);
      end

      r_dir  <= w_dir_nxt;
      r_bcnt <= w_bcnt_nxt;

      if (w_step) begin
        for (int i = 0; i < N_LEDS; i++) begin
          r_duty[i] <= w_duty_rot[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_chaser.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_led_chaser
// Description : Self-checking bench for pwm_led_chaser. Instance A (4 LEDs,
//               period 8, step 5) is followed cycle by cycle by a reference
//               model that tracks the profile as a rotation offset; its
//               per-cycle expectations go through a scoreboard queue. A
//               vector table plus hand-written sequences check step latency
//               and measured duty levels. Instance B (10 LEDs, period 100,
//               step 4) covers reset on a step edge and the 30/100 channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_led_chaser;

  localparam int NA = 4;
  localparam int PA = 8;
  localparam int SA = 5;
  localparam int NB = 10;
  localparam int PB = 100;
  localparam int SB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1, en_a = 1'b0, sen_a = 1'b0, mode_a = 1'b0;
  logic [NA-1:0] led_a;
  logic          step_a;
  logic          rst_b = 1'b1, en_b = 1'b0, sen_b = 1'b0, mode_b = 1'b0;
  logic [NB-1:0] led_b;
  logic          step_b;

  int checks = 0;
  int errors = 0;

  pwm_led_chaser #(.N_LEDS(NA), .PWM_PERIOD(PA), .STEP_TICKS(SA)) u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .sentido(sen_a), .mode(mode_a),
    .led(led_a), .step_o(step_a)
  );

  pwm_led_chaser #(.N_LEDS(NB), .PWM_PERIOD(PB), .STEP_TICKS(SB)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sentido(sen_b), .mode(mode_b),
    .led(led_b), .step_o(step_b)
  );

  // Level actually seen on an LED for a stored duty value.
  function automatic int ga(input int d);
`ifdef PWM_LED_GAMMA_EN
    return (d * d) / PA;
`else
    return d;
`endif
  endfunction

  function automatic int gb(input int d);
`ifdef PWM_LED_GAMMA_EN
    return (d * d) / PB;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model for instance A: profile = initial profile shifted by
  // m_off positions; one expectation record per clock edge.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [NA-1:0] led;
    logic          step;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  exp_t m_g;
  int   m_off = 0, m_dir = 1, m_bcnt = 0, m_pc = 0, m_sc = 0;

  function automatic int m_duty(input int i);
    return (((i + m_off) % NA) * PA) / NA;
  endfunction

  always @(posedge clk) begin
    if (rst_a) begin
      m_off = 0; m_dir = 1; m_bcnt = 0; m_pc = 0; m_sc = 0;
      m_e   = '0;
    end else begin
      for (int i = 0; i < NA; i++) m_e.led[i] = (m_pc < ga(m_duty(i)));
      m_pc   = (m_pc + 1) % PA;
      m_e.step = 1'b0;
      if (en_a) begin
        if (m_sc == SA - 1) begin
          m_sc     = 0;
          m_e.step = 1'b1;
          if (!mode_a) begin
            m_dir  = sen_a ? 1 : 0;
            m_bcnt = 0;
          end
          m_off = (m_dir != 0) ? (m_off + 1) % NA : (m_off + NA - 1) % NA;
          if (mode_a) begin
            if (m_bcnt == NA - 2) begin
              m_bcnt = 0;
              m_dir  = 1 - m_dir;
            end else begin
              m_bcnt++;
            end
          end
        end else begin
          m_sc++;
        end
      end
    end
    sb.push_back(m_e);
  end

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      m_g = sb.pop_front();
      checks++;
      if (led_a !== m_g.led) begin
        errors++;
        $display("FAIL sb_led t=%0t: got %b, expected %b", $time, led_a, m_g.led);
      end
      checks++;
      if (step_a !== m_g.step) begin
        errors++;
        $display("FAIL sb_step t=%0t: got %b, expected %b", $time, step_a, m_g.step);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers (all return at #1 after a rising edge)
  // --------------------------------------------------------------------------
  int ca [NA];
  int cb [NB];
  int sa_seen;

  task automatic meas_a();
    for (int i = 0; i < NA; i++) ca[i] = 0;
    sa_seen = 0;
    @(posedge clk); #1;
    repeat (PA) begin
      @(posedge clk); #1;
      for (int i = 0; i < NA; i++) ca[i] += int'(led_a[i]);
      sa_seen += int'(step_a);
    end
  endtask

  task automatic meas_b();
    for (int i = 0; i < NB; i++) cb[i] = 0;
    @(posedge clk); #1;
    repeat (PB) begin
      @(posedge clk); #1;
      for (int i = 0; i < NB; i++) cb[i] += int'(led_b[i]);
    end
  endtask

  task automatic wait_step_a(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step_a && n < 50);
  endtask

  task automatic wait_step_b(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step_b && n < 50);
  endtask

  task automatic pulse_rst_a();
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Vector table: one step per record, then the profile is measured frozen.
  // --------------------------------------------------------------------------
  typedef struct {
    bit do_rst;
    bit mode;
    bit sen;
    int gap;
    int d [NA];
  } vec_t;

  localparam int NVEC = 11;
  vec_t tbl [NVEC];

  task automatic set_vec(input int k, input bit r, input bit m, input bit s,
                         input int g, input int d0, input int d1,
                         input int d2, input int d3);
    tbl[k].do_rst = r;
    tbl[k].mode   = m;
    tbl[k].sen    = s;
    tbl[k].gap    = g;
    tbl[k].d[0]   = d0;
    tbl[k].d[1]   = d1;
    tbl[k].d[2]   = d2;
    tbl[k].d[3]   = d3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;

    // rotate toward 0, twice, then back
    set_vec(0,  1, 0, 1, SA, 2, 4, 6, 0);
    set_vec(1,  0, 0, 1, SA, 4, 6, 0, 2);
    set_vec(2,  0, 0, 0, SA, 2, 4, 6, 0);
    // bounce: three steps one way, three back (sentido ignored)
    set_vec(3,  1, 1, 0, SA, 2, 4, 6, 0);
    set_vec(4,  0, 1, 0, SA, 4, 6, 0, 2);
    set_vec(5,  0, 1, 1, SA, 6, 0, 2, 4);
    set_vec(6,  0, 1, 0, SA, 4, 6, 0, 2);
    set_vec(7,  0, 1, 0, SA, 2, 4, 6, 0);
    set_vec(8,  0, 1, 0, SA, 0, 2, 4, 6);
    // bounce -> rotate, then rotate -> bounce keeps last direction
    set_vec(9,  0, 0, 1, SA, 2, 4, 6, 0);
    set_vec(10, 0, 1, 0, SA, 4, 6, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset profile, en low: duties 0,2,4,6 and no strobe.
    chk("t1_led_after_reset", int'(led_a), 0);
    meas_a();
    for (int i = 0; i < NA; i++) chk($sformatf("t1_duty%0d", i), ca[i], ga(2 * i));
    chk("t1_step_o_highs", sa_seen, 0);

    for (int k = 0; k < NVEC; k++) begin
      if (tbl[k].do_rst) pulse_rst_a();
      mode_a = tbl[k].mode;
      sen_a  = tbl[k].sen;
      en_a   = 1'b1;
      wait_step_a(n);
      en_a   = 1'b0;
      chk($sformatf("vec%0d_gap", k), n, tbl[k].gap);
      meas_a();
      for (int i = 0; i < NA; i++)
        chk($sformatf("vec%0d_duty%0d", k, i), ca[i], ga(tbl[k].d[i]));
    end

    // en dropped for 20 clocks after 2 enabled clocks: 3 more needed.
    pulse_rst_a();
    mode_a = 1'b0;
    sen_a  = 1'b1;
    en_a   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    en_a = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    en_a = 1'b1;
    wait_step_a(n);
    en_a = 1'b0;
    chk("t4_resume_gap", n, SA - 2);

    // en falls exactly when the step is due: held until en returns.
    en_a = 1'b1;
    repeat (SA - 1) begin @(posedge clk); #1; end
    en_a = 1'b0;
    hi = 0;
    repeat (7) begin @(posedge clk); #1; hi += int'(step_a); end
    chk("t4_no_step_while_off", hi, 0);
    en_a = 1'b1;
    wait_step_a(n);
    en_a = 1'b0;
    chk("t4_due_step_gap", n, 1);
    meas_a();
    for (int i = 0; i < NA; i++)
      chk($sformatf("t4_duty%0d", i), ca[i], ga(2 * ((i + 2) % NA)));

    // Instance B: reset profile 0,10,...,90 (channel 3 = 30).
    meas_b();
    for (int i = 0; i < NB; i++) chk($sformatf("t6_duty%0d", i), cb[i], gb(10 * i));

    sen_b = 1'b1;
    en_b  = 1'b1;
    wait_step_b(n);
    en_b  = 1'b0;
    chk("t5_first_step_gap", n, SB);
    meas_b();
    chk("t5_rot_duty0", cb[0], gb(10));
    chk("t5_rot_duty9", cb[NB-1], gb(0));

    // Reset lands on the edge where the next step is due.
    en_b = 1'b1;
    repeat (SB - 1) begin @(posedge clk); #1; end
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("t5_step_o_at_rst_edge", int'(step_b), 0);
    rst_b = 1'b0;
    en_b  = 1'b0;
    @(posedge clk); #1;
    chk("t5_step_o_after_rst", int'(step_b), 0);
    meas_b();
    for (int i = 0; i < NB; i++) chk($sformatf("t5_duty%0d", i), cb[i], gb(10 * i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
